// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker: debounces the per-frame FFT peak-bin index into a stable
// tracked bin with lock / hold qualification for the PIO/NIOS side.
//
// Ports:
//   clk_clk        in   system clock
//   reset_reset_n  in   async active-low reset
//   idx_in         in   peak bin from the FFT max-index stage
//   idx_valid      in   one-cycle strobe, idx_in valid
//   track_index    out  tracked bin (qualified by locked)
//   locked         out  track_index is qualified
//   holding        out  locked but currently missing
//   lock_change    out  one-cycle pulse on any change of locked
//   timeout_flag   out  sticky idle-timeout indicator, cleared on next lock
//
// Optional feature: define FFT_PEAK_TRACK_TIMEOUT_EN to build the idle
// timeout (adds parameter TIMEOUT_CYCLES). Without it timeout_flag is 0.
module fft_peak_tracker #(
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TOL        = 1,
  parameter int unsigned LOSS_COUNT = 3
`ifdef FFT_PEAK_TRACK_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [IDX_W-1:0] idx_in,
  input  logic             idx_valid,
  output logic [IDX_W-1:0] track_index,
  output logic             locked,
  output logic             holding,
  output logic             lock_change,
  output logic             timeout_flag
);

  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT) + 1;
  localparam int unsigned MISS_W  = $clog2(LOSS_COUNT) + 1;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED, HOLD} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cand_q, cand_d, track_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               locked_d, holding_d, lock_change_d, timeout_flag_d;

  logic [IDX_W-1:0]   ref_c, dist_c;
  logic               nonzero_c, hit_c, timeout_c;

  // Reference is the candidate while acquiring, the tracked bin otherwise.
  always_comb begin
    ref_c     = (state_q == ACQUIRE) ? cand_q : track_index;
    dist_c    = (idx_in > ref_c) ? (idx_in - ref_c) : (ref_c - idx_in);
    nonzero_c = (idx_in != '0);
    // DC bin never counts as a hit, even when within tolerance of ref.
    hit_c     = nonzero_c && (32'(dist_c) <= TOL);
  end

`ifdef FFT_PEAK_TRACK_TIMEOUT_EN
  localparam int unsigned TOUT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TOUT_W-1:0] idle_q, idle_d;

  // Idle counter; a strobe on the terminal cycle wins over the timeout.
  always_comb begin
    idle_d    = idle_q;
    timeout_c = 1'b0;
    if (idx_valid || state_q == SEARCH) begin
      idle_d = '0;
    end else if (idle_q == TOUT_W'(TIMEOUT_CYCLES - 1)) begin
      idle_d    = '0;
      timeout_c = 1'b1;
    end else begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) idle_q <= '0;
    else                idle_q <= idle_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    cand_d         = cand_q;
    track_d        = track_index;
    match_d        = match_q;
    miss_d         = miss_q;
    locked_d       = locked;
    holding_d      = holding;
    lock_change_d  = 1'b0;
    timeout_flag_d = timeout_flag;

    if (timeout_c) begin
      state_d        = SEARCH;
      match_d        = '0;
      miss_d         = '0;
      holding_d      = 1'b0;
      timeout_flag_d = 1'b1;
      if (locked) begin
        locked_d      = 1'b0;
        lock_change_d = 1'b1;
      end
    end else if (idx_valid) begin
      unique case (state_q)
        SEARCH: begin
          if (nonzero_c) begin
            cand_d  = idx_in;
            match_d = MATCH_W'(1);
            state_d = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (nonzero_c) begin
            if (hit_c) begin
              if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
                track_d        = cand_q;
                locked_d       = 1'b1;
                lock_change_d  = 1'b1;
                timeout_flag_d = 1'b0;
                match_d        = '0;
                state_d        = LOCKED;
              end else begin
                match_d = match_q + 1'b1;
              end
            end else begin
              cand_d  = idx_in;
              match_d = MATCH_W'(1);
            end
          end
        end
        LOCKED: begin
          if (hit_c) begin
            track_d = idx_in;
          end else if (LOSS_COUNT == 1) begin
            locked_d      = 1'b0;
            lock_change_d = 1'b1;
            state_d       = SEARCH;
          end else begin
            miss_d    = MISS_W'(1);
            holding_d = 1'b1;
            state_d   = HOLD;
          end
        end
        HOLD: begin
          if (hit_c) begin
            track_d   = idx_in;
            miss_d    = '0;
            holding_d = 1'b0;
            state_d   = LOCKED;
          end else if (miss_q == MISS_W'(LOSS_COUNT - 1)) begin
            miss_d        = '0;
            locked_d      = 1'b0;
            holding_d     = 1'b0;
            lock_change_d = 1'b1;
            state_d       = SEARCH;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= SEARCH;
      cand_q       <= '0;
      match_q      <= '0;
      miss_q       <= '0;
      track_index  <= '0;
      locked       <= 1'b0;
      holding      <= 1'b0;
      lock_change  <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      match_q      <= match_d;
      miss_q       <= miss_d;
      track_index  <= track_d;
      locked       <= locked_d;
      holding      <= holding_d;
      lock_change  <= lock_change_d;
      timeout_flag <= timeout_flag_d;
    end
  end

endmodule

// File: tb/tb_fft_peak_tracker.sv
// Scoreboard bench for fft_peak_tracker: each driven cycle pushes the
// hand-computed output vector expected after that edge; a monitor pops and
// compares one entry per clock.
module tb_fft_peak_tracker;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [7:0] idx_in;
  logic       idx_valid;
  logic [7:0] track_index;
  logic       locked, holding, lock_change, timeout_flag;

  always #5 clk_clk = ~clk_clk;

`ifdef FFT_PEAK_TRACK_TIMEOUT_EN
  fft_peak_tracker #(.IDX_W(8), .LOCK_COUNT(4), .TOL(1), .LOSS_COUNT(3),
                     .TIMEOUT_CYCLES(100)) dut (
`else
  fft_peak_tracker #(.IDX_W(8), .LOCK_COUNT(4), .TOL(1), .LOSS_COUNT(3)) dut (
`endif
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .idx_in        (idx_in),
    .idx_valid     (idx_valid),
    .track_index   (track_index),
    .locked        (locked),
    .holding       (holding),
    .lock_change   (lock_change),
    .timeout_flag  (timeout_flag)
  );

  typedef struct packed {
    logic [7:0] trk;
    logic       lk;
    logic       hd;
    logic       lc;
    logic       tf;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  // One driven cycle plus the outputs expected right after its edge.
  task automatic step(input logic v, input logic [7:0] idx, input logic [7:0] trk,
                      input logic lk, input logic hd, input logic lc, input logic tf,
                      input string tag);
    exp_t e;
    @(negedge clk_clk);
    idx_valid = v;
    idx_in    = idx;
    e = '{trk: trk, lk: lk, hd: hd, lc: lc, tf: tf};
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input int n, input logic [7:0] trk, input logic lk,
                      input logic hd, input logic tf, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, trk, lk, hd, 1'b0, tf, tag);
  endtask

  task automatic do_reset();
    @(negedge clk_clk);
    idx_valid     = 1'b0;
    idx_in        = 8'd0;
    reset_reset_n = 1'b0;
    #12;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
  endtask

  // Four strobes of 40 from SEARCH: lock on the fourth.
  task automatic lock40(input logic tf_before);
    step(1'b1, 8'd40, 8'd0, 1'b0, 1'b0, 1'b0, tf_before, "lk40_1");
    step(1'b1, 8'd40, 8'd0, 1'b0, 1'b0, 1'b0, tf_before, "lk40_2");
    step(1'b1, 8'd40, 8'd0, 1'b0, 1'b0, 1'b0, tf_before, "lk40_3");
    step(1'b1, 8'd40, 8'd40, 1'b1, 1'b0, 1'b1, 1'b0, "lk40_4");
  endtask

  // Monitor: compare one expected vector per clock, shortly after the edge.
  always @(posedge clk_clk) begin
    exp_t  e;
    exp_t  a;
    string t;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = '{trk: track_index, lk: locked, hd: holding, lc: lock_change, tf: timeout_flag};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got trk=%0d lk=%b hd=%b lc=%b tf=%b, want trk=%0d lk=%b hd=%b lc=%b tf=%b",
                 t, a.trk, a.lk, a.hd, a.lc, a.tf, e.trk, e.lk, e.hd, e.lc, e.tf);
      end
    end
  end

  initial begin
    reset_reset_n = 1'b0;
    idx_valid     = 1'b0;
    idx_in        = 8'd0;
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;

    // Reset state held over idle cycles.
    idle(10, 8'd0, 1'b0, 1'b0, 1'b0, "reset_idle");

    // Lock within tolerance window around the candidate.
    step(1'b1, 8'd40, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "acq_40");
    step(1'b1, 8'd41, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "acq_41");
    step(1'b1, 8'd40, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "acq_40b");
    step(1'b1, 8'd39, 8'd40, 1'b1, 1'b0, 1'b1, 1'b0, "lock_39");
    idle(2, 8'd40, 1'b1, 1'b0, 1'b0, "locked_idle");

    // DC ignored in SEARCH, candidate restarts on a far miss.
    do_reset();
    step(1'b1, 8'd0,  8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "dc_search1");
    step(1'b1, 8'd0,  8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "dc_search2");
    step(1'b1, 8'd40, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "acq2_40");
    step(1'b1, 8'd41, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "acq2_41");
    step(1'b1, 8'd45, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "acq2_45a");
    step(1'b1, 8'd45, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "acq2_45b");
    step(1'b1, 8'd45, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "acq2_45c");
    step(1'b1, 8'd45, 8'd45, 1'b1, 1'b0, 1'b1, 1'b0, "acq2_45d");

    // DC ignored in ACQUIRE: count continues across it.
    do_reset();
    step(1'b1, 8'd40, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "acq3_40");
    step(1'b1, 8'd0,  8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "acq3_dc");
    step(1'b1, 8'd41, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "acq3_41");
    step(1'b1, 8'd40, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "acq3_40b");
    step(1'b1, 8'd39, 8'd40, 1'b1, 1'b0, 1'b1, 1'b0, "acq3_lock");

    // Loss of lock after three misses; track_index retained.
    do_reset();
    lock40(1'b0);
    step(1'b1, 8'd90, 8'd40, 1'b1, 1'b1, 1'b0, 1'b0, "loss_m1");
    step(1'b1, 8'd90, 8'd40, 1'b1, 1'b1, 1'b0, 1'b0, "loss_m2");
    step(1'b1, 8'd90, 8'd40, 1'b0, 1'b0, 1'b1, 1'b0, "loss_m3");
    idle(1, 8'd40, 1'b0, 1'b0, 1'b0, "lost_idle");
    step(1'b1, 8'd90, 8'd40, 1'b0, 1'b0, 1'b0, 1'b0, "lost_search");

    // Recovery from HOLD, drift following, tolerance edge, DC as miss.
    do_reset();
    lock40(1'b0);
    step(1'b1, 8'd90, 8'd40, 1'b1, 1'b1, 1'b0, 1'b0, "hold_90");
    step(1'b1, 8'd41, 8'd41, 1'b1, 1'b0, 1'b0, 1'b0, "recover_41");
    step(1'b1, 8'd0,  8'd41, 1'b1, 1'b1, 1'b0, 1'b0, "dc_miss");
    step(1'b1, 8'd42, 8'd42, 1'b1, 1'b0, 1'b0, 1'b0, "recover_42");
    step(1'b1, 8'd43, 8'd43, 1'b1, 1'b0, 1'b0, 1'b0, "drift_43");
    step(1'b1, 8'd45, 8'd43, 1'b1, 1'b1, 1'b0, 1'b0, "tol_edge_45");
    step(1'b1, 8'd44, 8'd44, 1'b1, 1'b0, 1'b0, 1'b0, "recover_44");

    // DC next to a bin-1 track is still a miss.
    do_reset();
    step(1'b1, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "b1_a");
    step(1'b1, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "b1_b");
    step(1'b1, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "b1_c");
    step(1'b1, 8'd1, 8'd1, 1'b1, 1'b0, 1'b1, 1'b0, "b1_lock");
    step(1'b1, 8'd0, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, "b1_dc_miss");
    step(1'b1, 8'd2, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, "b1_recover");

`ifdef FFT_PEAK_TRACK_TIMEOUT_EN
    // Strobe on the terminal idle cycle suppresses timeout; then it fires.
    do_reset();
    lock40(1'b0);
    idle(99, 8'd40, 1'b1, 1'b0, 1'b0, "to_wait1");
    step(1'b1, 8'd40, 8'd40, 1'b1, 1'b0, 1'b0, 1'b0, "to_suppress");
    idle(99, 8'd40, 1'b1, 1'b0, 1'b0, "to_wait2");
    step(1'b0, 8'd0, 8'd40, 1'b0, 1'b0, 1'b1, 1'b1, "to_fire");
    idle(2, 8'd40, 1'b0, 1'b0, 1'b1, "to_sticky");
    lock40(1'b1);
`endif

    // Drain the scoreboard with a bounded wait.
    @(negedge clk_clk);
    idx_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
